// File: rtl/qpix_top_rtl.sv
// QPix readout control core: timestamps oLVDS hit edges into an event FIFO and
// drives the two ASIC serial configuration ports, reset, startup and replenishment pins.

module qpix_serial #(
  parameter int CLK_DIV    = 4,
  parameter int LOAD_PULSE = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srst,
  input  logic        load_sr,
  input  logic        shift,
  input  logic        load_pls,
  input  logic        sel_def_in,
  input  logic [31:0] data,
  output logic        sclk,
  output logic        sdata,
  output logic        load_data,
  output logic        sel_def
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(LOAD_PULSE + 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PULSE_MAX = PW'(LOAD_PULSE - 1);

  logic          load_sr_prev_q, load_sr_prev_d, shift_prev_q, shift_prev_d;
  logic          ld_prev_q, ld_prev_d, sel_def_q, sel_def_d;
  logic [31:0]   sr_q, sr_d;
  logic [5:0]    bits_q, bits_d;
  logic [DW-1:0] div_q, div_d;
  logic          active_q, active_d, sclk_q, sclk_d, sdata_q, sdata_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          load_data_q, load_data_d;
  logic          start;

  always_comb begin
    load_sr_prev_d = load_sr;
    shift_prev_d   = shift;
    ld_prev_d      = load_pls;
    sel_def_d      = sel_def_in;
    sr_d           = sr_q;
    bits_d         = bits_q;
    div_d          = div_q;
    active_d       = active_q;
    sclk_d         = sclk_q;
    sdata_d        = sdata_q;
    pcnt_d         = pcnt_q;
    load_data_d    = load_data_q;
    start          = shift && !shift_prev_q && !active_q;

    if (load_sr && !load_sr_prev_q && !active_q && !start)
      sr_d = data;

    // sdata only moves on the falling half of sclk; the last fall ends the transfer
    if (start) begin
      active_d = 1'b1;
      bits_d   = 6'd32;
      div_d    = '0;
      sclk_d   = 1'b0;
      sdata_d  = sr_q[31];
    end else if (active_q && shift) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bits_q == 6'd1) begin
            active_d = 1'b0;
            bits_d   = 6'd0;
            sdata_d  = 1'b0;
          end else begin
            bits_d  = bits_q - 6'd1;
            sr_d    = sr_q << 1;
            sdata_d = sr_q[30];
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (load_data_q) begin
      if (pcnt_q == '0) load_data_d = 1'b0;
      else              pcnt_d      = pcnt_q - 1'b1;
    end else if (load_pls && !ld_prev_q) begin
      load_data_d = 1'b1;
      pcnt_d      = PULSE_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || srst) begin
      load_sr_prev_q <= 1'b0;
      shift_prev_q   <= 1'b0;
      ld_prev_q      <= 1'b0;
      sel_def_q      <= 1'b0;
      sr_q           <= '0;
      bits_q         <= '0;
      div_q          <= '0;
      active_q       <= 1'b0;
      sclk_q         <= 1'b0;
      sdata_q        <= 1'b0;
      pcnt_q         <= '0;
      load_data_q    <= 1'b0;
    end else begin
      load_sr_prev_q <= load_sr_prev_d;
      shift_prev_q   <= shift_prev_d;
      ld_prev_q      <= ld_prev_d;
      sel_def_q      <= sel_def_d;
      sr_q           <= sr_d;
      bits_q         <= bits_d;
      div_q          <= div_d;
      active_q       <= active_d;
      sclk_q         <= sclk_d;
      sdata_q        <= sdata_d;
      pcnt_q         <= pcnt_d;
      load_data_q    <= load_data_d;
    end
  end

  assign sclk      = sclk_q;
  assign sdata     = sdata_q;
  assign load_data = load_data_q;
  assign sel_def   = sel_def_q;
endmodule

module qpix_top_rtl #(
  parameter int CLK_DIV    = 4,
  parameter int LOAD_PULSE = 20,
  parameter int REPL_DIV   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   oLVDS,
  input  logic [2047:0]                 reg_rw,
  output logic [31:0]                   fifo_dout,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          fifo_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    sclk,
  output logic [1:0]                    sdata,
  output logic [1:0]                    load_data,
  output logic [1:0]                    sel_def,
  output logic                          rst_ext,
  output logic                          rst_ext2,
  output logic                          opad_clk,
  output logic                          opad2_clk,
  output logic                          opad_startup,
  output logic                          opad_startup2
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (REPL_DIV > 1) ? $clog2(REPL_DIV) : 1;
  localparam logic [RW-1:0] REPL_MAX = RW'(REPL_DIV - 1);

  logic srst, trigger, unused_reg;
  assign srst       = reg_rw[0];
  assign trigger    = reg_rw[160];
  assign unused_reg = ^reg_rw;

  logic [15:0]       sync1_q, sync2_q, sync3_q, rise;
  logic [27:0]       ts_q, ts_d;
  logic [15:0]       pend_q, pend_d;
  logic [15:0][27:0] ts_lat_q, ts_lat_d;
  logic              push;
  logic [3:0]        push_ch;
  logic [31:0]       push_word;

  logic              rd_sync_q, rd_prev_q, pop_req, do_pop, do_push;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [31:0]       dout_q, dout_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic [1:0][RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]         opad_q, opad_d, repl_en;
  logic [3:0]         ctl_q, ctl_d;

  assign rise    = sync2_q & ~sync3_q;
  assign pop_req = rd_sync_q & ~rd_prev_q;
  assign repl_en = reg_rw[17:16];

  // Lowest pending channel wins; a fresh edge on the channel being drained re-arms it
  always_comb begin
    push    = 1'b0;
    push_ch = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) begin
        push    = 1'b1;
        push_ch = 4'(i);
      end
    end
    push_word = {push_ch, ts_lat_q[push_ch]};
    ts_d      = ts_q + 28'd1;
    pend_d    = pend_q;
    ts_lat_d  = ts_lat_q;
    if (push) pend_d[push_ch] = 1'b0;
    if (trigger) begin
      pend_d = pend_d | rise;
      for (int i = 0; i < 16; i++)
        if (rise[i]) ts_lat_d[i] = ts_q;
    end
  end

  always_comb begin
    do_pop   = pop_req && (count_q != '0);
    do_push  = push && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
    ovf_d    = ovf_q | (push && !do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout_d   = do_pop  ? mem_q[rd_ptr_q] : dout_q;
    empty_d  = (count_d == '0);
    full_d   = (count_d == CW'(FIFO_DEPTH));
  end

  always_comb begin
    ctl_d = {reg_rw[25], reg_rw[24], reg_rw[3], reg_rw[2]};
    for (int i = 0; i < 2; i++) begin
      rcnt_d[i] = rcnt_q[i];
      opad_d[i] = opad_q[i];
      if (!repl_en[i]) begin
        rcnt_d[i] = '0;
        opad_d[i] = 1'b0;
      end else if (rcnt_q[i] == REPL_MAX) begin
        rcnt_d[i] = '0;
        opad_d[i] = ~opad_q[i];
      end else begin
        rcnt_d[i] = rcnt_q[i] + 1'b1;
      end
    end
  end

  // Storage is never reset; pointers and count alone define the FIFO contents
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || srst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      ts_q      <= '0;
      pend_q    <= '0;
      ts_lat_q  <= '0;
      rd_sync_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
      rcnt_q    <= '0;
      opad_q    <= '0;
      ctl_q     <= '0;
    end else begin
      sync1_q   <= oLVDS;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      ts_q      <= ts_d;
      pend_q    <= pend_d;
      ts_lat_q  <= ts_lat_d;
      rd_sync_q <= reg_rw[192];
      rd_prev_q <= rd_sync_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
      rcnt_q    <= rcnt_d;
      opad_q    <= opad_d;
      ctl_q     <= ctl_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ser
    qpix_serial #(.CLK_DIV(CLK_DIV), .LOAD_PULSE(LOAD_PULSE)) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .srst       (srst),
      .load_sr    (reg_rw[33 + 64*g]),
      .shift      (reg_rw[34 + 64*g]),
      .load_pls   (reg_rw[40 + 64*g]),
      .sel_def_in (reg_rw[41 + 64*g]),
      .data       (reg_rw[64 + 64*g +: 32]),
      .sclk       (sclk[g]),
      .sdata      (sdata[g]),
      .load_data  (load_data[g]),
      .sel_def    (sel_def[g])
    );
  end

  assign fifo_dout     = dout_q;
  assign fifo_empty    = empty_q;
  assign fifo_full     = full_q;
  assign fifo_ovf      = ovf_q;
  assign fifo_count    = count_q;
  assign rst_ext       = ctl_q[0];
  assign rst_ext2      = ctl_q[1];
  assign opad_startup  = ctl_q[2];
  assign opad_startup2 = ctl_q[3];
  assign opad_clk      = opad_q[0];
  assign opad2_clk     = opad_q[1];
endmodule

// File: tb/tb_qpix_top_rtl.sv
// Scoreboard bench for qpix_top_rtl: events and serial bits are queued when issued,
// independent monitors compare them when the DUT pops a word or raises sclk.
module tb_qpix_top_rtl;
  localparam int CLK_DIV    = 4;
  localparam int LOAD_PULSE = 20;
  localparam int REPL_DIV   = 8;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   oLVDS;
  logic [2047:0] reg_rw;
  logic [31:0]   fifo_dout;
  logic          fifo_empty, fifo_full, fifo_ovf;
  logic [4:0]    fifo_count;
  logic [1:0]    sclk, sdata, load_data, sel_def;
  logic          rst_ext, rst_ext2, opad_clk, opad2_clk, opad_startup, opad_startup2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        sq0[$];
  logic        sq1[$];
  logic [31:0] last_exp = 32'h0;
  logic [27:0] tb_ts = '0;
  int          prev_cnt = 0;
  int          rises0 = 0;
  int          rises1 = 0;

  qpix_top_rtl #(
    .CLK_DIV(CLK_DIV), .LOAD_PULSE(LOAD_PULSE), .REPL_DIV(REPL_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oLVDS(oLVDS), .reg_rw(reg_rw),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ovf(fifo_ovf), .fifo_count(fifo_count),
    .sclk(sclk), .sdata(sdata), .load_data(load_data), .sel_def(sel_def),
    .rst_ext(rst_ext), .rst_ext2(rst_ext2), .opad_clk(opad_clk), .opad2_clk(opad2_clk),
    .opad_startup(opad_startup), .opad_startup2(opad_startup2)
  );

  always #2.5 clk = ~clk;

  // Reference timestamp: free-running, cleared by either reset source
  always @(posedge clk) begin
    if (!rst_n || reg_rw[0]) tb_ts <= '0;
    else                     tb_ts <= tb_ts + 28'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a 2-cycle pulse on the masked lines and queue the events it should create
  task automatic applyStimulus(input logic [15:0] mask, input bit accept);
    @(posedge clk); #1;
    oLVDS = mask;
    if (accept && reg_rw[160])
      for (int ch = 0; ch < 16; ch++)
        if (mask[ch]) exp_q.push_back({4'(ch), tb_ts + 28'd2});
    repeat (2) @(posedge clk);
    #1 oLVDS = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic popOnce();
    @(posedge clk); #1 reg_rw[192] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reg_rw[192] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic masterReset(input int cycles);
    @(posedge clk); #1 reg_rw[0] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reg_rw[0] = 1'b0;
    exp_q.delete();
  endtask

  // FIFO monitor: a count drop of one means a word was popped into fifo_dout
  always @(negedge clk) begin
    if (rst_n && !reg_rw[0] && (int'(fifo_count) == prev_cnt - 1)) begin
      if (exp_q.size() == 0) begin
        checkOutput("pop_unexpected", fifo_dout, 32'hxxxx_xxxx);
      end else begin
        last_exp = exp_q.pop_front();
        checkOutput("pop_event", fifo_dout, last_exp);
      end
    end
    prev_cnt = int'(fifo_count);
  end

  always @(posedge sclk[0]) begin
    #1;
    rises0++;
    if (sq0.size() == 0) checkOutput("sdata0_extra", {31'd0, sdata[0]}, 32'hxxxx_xxxx);
    else                 checkOutput("sdata0_bit", {31'd0, sdata[0]}, {31'd0, sq0.pop_front()});
  end

  always @(posedge sclk[1]) begin
    #1;
    rises1++;
    if (sq1.size() == 0) checkOutput("sdata1_extra", {31'd0, sdata[1]}, 32'hxxxx_xxxx);
    else                 checkOutput("sdata1_bit", {31'd0, sdata[1]}, {31'd0, sq1.pop_front()});
  end

  initial begin
    logic [31:0] w;
    int hi0, hi1, r1, r2, f1;
    logic prev;

    rst_n  = 1'b0;
    oLVDS  = '0;
    reg_rw = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("rst_count", {27'd0, fifo_count}, 32'd0);
    checkOutput("rst_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_ovf", {31'd0, fifo_ovf}, 32'd0);
    checkOutput("rst_dout", fifo_dout, 32'd0);
    checkOutput("rst_serial", {24'd0, sclk, sdata, load_data, sel_def}, 32'd0);
    checkOutput("rst_pins", {26'd0, rst_ext, rst_ext2, opad_clk, opad2_clk, opad_startup, opad_startup2}, 32'd0);
    rst_n = 1'b1;

    masterReset(100);
    reg_rw[160] = 1'b1;
    repeat (3) @(posedge clk);

    // First event with latency check: count moves on the fourth edge after the drive
    @(posedge clk); #1;
    oLVDS = 16'h0001;
    exp_q.push_back({4'd0, tb_ts + 28'd2});
    repeat (2) @(posedge clk);
    #1 oLVDS = '0;
    @(posedge clk); #1;
    checkOutput("evt_latency_before", {27'd0, fifo_count}, 32'd0);
    @(posedge clk); #1;
    checkOutput("evt_latency_at", {27'd0, fifo_count}, 32'd1);
    repeat (95) @(posedge clk);
    applyStimulus(16'h0001, 1'b1);
    repeat (4) @(posedge clk);
    checkOutput("two_events_count", {27'd0, fifo_count}, 32'd2);

    @(posedge clk); #1 reg_rw[192] = 1'b1;
    @(posedge clk); #1;
    checkOutput("pop_latency_before", {27'd0, fifo_count}, 32'd2);
    @(posedge clk); #1;
    checkOutput("pop_latency_at", {27'd0, fifo_count}, 32'd1);
    reg_rw[192] = 1'b0;
    repeat (2) @(posedge clk);
    popOnce();
    #1;
    checkOutput("empty_after_pops", {31'd0, fifo_empty}, 32'd1);
    popOnce();
    #1;
    checkOutput("pop_empty_dout_hold", fifo_dout, last_exp);
    checkOutput("pop_empty_count", {27'd0, fifo_count}, 32'd0);

    applyStimulus(16'h000A, 1'b1);
    repeat (4) @(posedge clk);
    checkOutput("pair_count", {27'd0, fifo_count}, 32'd2);
    popOnce();
    popOnce();

    reg_rw[160] = 1'b0;
    applyStimulus(16'h0004, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("trigger_off_count", {27'd0, fifo_count}, 32'd0);
    reg_rw[160] = 1'b1;

    for (int i = 0; i <= FIFO_DEPTH; i++)
      applyStimulus(16'(1 << (i % 16)), i < FIFO_DEPTH);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("ovf_count", {27'd0, fifo_count}, FIFO_DEPTH);
    checkOutput("ovf_full", {31'd0, fifo_full}, 32'd1);
    checkOutput("ovf_flag", {31'd0, fifo_ovf}, 32'd1);
    for (int i = 0; i < FIFO_DEPTH; i++) popOnce();
    #1;
    checkOutput("drain_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("ovf_sticky", {31'd0, fifo_ovf}, 32'd1);
    checkOutput("drain_scoreboard", exp_q.size(), 32'd0);
    masterReset(2);
    @(posedge clk); #1;
    checkOutput("mrst_ovf", {31'd0, fifo_ovf}, 32'd0);
    checkOutput("mrst_empty", {31'd0, fifo_empty}, 32'd1);

    w = 32'h0000_8000;
    reg_rw[95:64] = w;
    for (int b = 31; b >= 0; b--) sq0.push_back(w[b]);
    @(posedge clk); #1 reg_rw[33] = 1'b1;
    @(posedge clk); #1 reg_rw[33] = 1'b0;
    @(posedge clk); #1 reg_rw[34] = 1'b1;
    @(posedge clk); #1;
    checkOutput("ser0_first_bit", {30'd0, sclk[0], sdata[0]}, 32'd0);
    repeat (255) @(posedge clk);
    #1;
    checkOutput("ser0_last_high", {31'd0, sclk[0]}, 32'd1);
    @(posedge clk); #1;
    checkOutput("ser0_idle", {30'd0, sclk[0], sdata[0]}, 32'd0);
    checkOutput("ser0_rises", rises0, 32'd32);
    checkOutput("ser0_queue", sq0.size(), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ser0_no_restart", rises0, 32'd32);
    reg_rw[34] = 1'b0;

    w = 32'h8000_0001;
    reg_rw[159:128] = w;
    for (int b = 31; b >= 0; b--) sq1.push_back(w[b]);
    @(posedge clk); #1 reg_rw[97] = 1'b1;
    @(posedge clk); #1 reg_rw[97] = 1'b0;
    @(posedge clk); #1 reg_rw[98] = 1'b1;
    @(posedge clk); #1;
    checkOutput("ser1_first_bit", {30'd0, sclk[1], sdata[1]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ser1_sclk_pre", {31'd0, sclk[1]}, 32'd0);
    @(posedge clk); #1;
    checkOutput("ser1_sclk_rise", {31'd0, sclk[1]}, 32'd1);
    repeat (251) @(posedge clk);
    #1;
    checkOutput("ser1_last_high", {31'd0, sclk[1]}, 32'd1);
    @(posedge clk); #1;
    checkOutput("ser1_idle", {30'd0, sclk[1], sdata[1]}, 32'd0);
    checkOutput("ser1_rises", rises1, 32'd32);
    checkOutput("ser1_queue", sq1.size(), 32'd0);
    checkOutput("ser0_untouched", rises0, 32'd32);
    reg_rw[98] = 1'b0;

    hi0 = 0;
    hi1 = 0;
    @(posedge clk); #1 reg_rw[40] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (load_data[0]) hi0++;
      if (load_data[1]) hi1++;
      if (c == 5) reg_rw[40] = 1'b0;
      if (c == 6) reg_rw[40] = 1'b1;
    end
    checkOutput("load_pulse_width", hi0, LOAD_PULSE);
    checkOutput("load_pulse_other", hi1, 32'd0);
    reg_rw[41] = 1'b1;
    @(posedge clk); #1;
    checkOutput("sel_def", {30'd0, sel_def}, 32'd1);

    reg_rw[2] = 1'b1; reg_rw[3] = 1'b1; reg_rw[24] = 1'b1; reg_rw[25] = 1'b1;
    @(posedge clk); #1;
    checkOutput("pins_high", {28'd0, rst_ext, rst_ext2, opad_startup, opad_startup2}, 32'hF);
    reg_rw[3] = 1'b0; reg_rw[24] = 1'b0;
    @(posedge clk); #1;
    checkOutput("pins_mixed", {28'd0, rst_ext, rst_ext2, opad_startup, opad_startup2}, 32'h9);

    for (int k = 0; k < 2; k++) begin
      reg_rw[16 + k] = 1'b1;
      r1 = -1; r2 = -1; f1 = -1;
      prev = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #1;
        if ((k == 0 ? opad_clk : opad2_clk) && !prev) begin
          if (r1 < 0) r1 = c;
          else if (r2 < 0) r2 = c;
        end
        if (!(k == 0 ? opad_clk : opad2_clk) && prev && r1 >= 0 && f1 < 0) f1 = c;
        prev = (k == 0) ? opad_clk : opad2_clk;
      end
      checkOutput(k == 0 ? "opad_period" : "opad2_period", r2 - r1, 2 * REPL_DIV);
      checkOutput(k == 0 ? "opad_high" : "opad2_high", f1 - r1, REPL_DIV);
      for (int c = 0; c < 40 && !(k == 0 ? opad_clk : opad2_clk); c++) begin
        @(posedge clk); #1;
      end
      reg_rw[16 + k] = 1'b0;
      @(posedge clk); #1;
      checkOutput(k == 0 ? "opad_disable" : "opad2_disable", {31'd0, (k == 0 ? opad_clk : opad2_clk)}, 32'd0);
    end

    checkOutput("final_scoreboard", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/qpix_top_rtl.md
# qpix_top_rtl

Register-mapped control core for a QPix readout board. It timestamps rising edges on 16 LVDS hit lines into an event FIFO and drives two 32-bit serial configuration interfaces to the ASICs. It also drives ASIC reset, startup and replenishment-clock pins. It sits between the processor register bank and the ASIC I/O pins.

## Interface

Parameters:
- `CLK_DIV`, default 4: serial clock half-period, in clk cycles.
- `LOAD_PULSE`, default 20: loadData pulse width, in clk cycles (20000 for real-time 100 µs at 200 MHz).
- `REPL_DIV`, default 8: replenishment clock half-period, in clk cycles.
- `FIFO_DEPTH`, default 16: event FIFO depth, in words (power of 2).

Ports:
- `clk` in 1: single 200 MHz clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `oLVDS` in 16: ASIC hit lines, asynchronous.
- `reg_rw` in 2048: 64×32 register bank; word n = `reg_rw[n*32+31 : n*32]`.
- `fifo_dout` out 32: last popped event, {ch[3:0], ts[27:0]}.
- `fifo_empty`, `fifo_full`, `fifo_ovf` out 1 each: FIFO status; `fifo_ovf` is sticky.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `sclk[1:0]`, `sdata[1:0]`, `load_data[1:0]`, `sel_def[1:0]` out: serial interface 1 on index 0, interface 2 on index 1.
- `rst_ext`, `rst_ext2`, `opad_clk`, `opad2_clk`, `opad_startup`, `opad_startup2` out 1 each: ASIC control pins.

## Operation

Register map:
- Word0 bit0: master reset. Synchronous, active-high. Same effect as `rst_n` except on the register bank itself.
- Word0 bits 2 and 3: drive `rst_ext` and `rst_ext2`.
- Word0 bits 16 and 17: enable `opad_clk` and `opad2_clk`.
- Word0 bits 24 and 25: drive `opad_startup` and `opad_startup2`.
- Word1 (interface 1) and word3 (interface 2): bit1 load SR, bit2 shift, bit8 loadData, bit9 selDefData.
- Word2 and word4: 32-bit data words for interfaces 1 and 2.
- Word5 bit0: trigger (event capture enable).
- Word6 bit0: FIFO read strobe.

Event capture:
- Each `oLVDS` bit passes through a 2-FF synchronizer, then a rising-edge detector.
- While trigger=1, a detected edge sets that channel's pending flag and latches the 28-bit timestamp.
- Each cycle, the lowest-indexed pending channel is pushed as {ch, ts}, and its flag is cleared.
- Edges seen while trigger=0 are ignored.
- Timestamp is a free-running 28-bit counter. It clears on reset and wraps from 0xFFFFFFF to 0.

FIFO:
- A rising edge of the word6 bit0 strobe pops the head into `fifo_dout`.
- Pop on empty: no effect.
- Push on full: word dropped and `fifo_ovf` set.
- Simultaneous push and pop: both occur and count is unchanged.

Serial interface, each instance independent:
- Rising edge of load SR: shift register ← data word.
- While shift=1 and bits remain: `sclk` toggles every `CLK_DIV` cycles. `sdata` presents the MSB first and changes on `sclk` falling edges.
- After 32 bits, `sclk` is held low and `sdata` low. Another transfer requires shift to fall and then rise again.
- A load SR edge during shifting is ignored.
- Rising edge of loadData: `load_data` goes high for exactly `LOAD_PULSE` cycles. A retrigger during the pulse is ignored.
- `sel_def` is a registered copy of selDefData.

Replenishment clocks:
- `opad_clk` and `opad2_clk` are 50% square waves with a half-period of `REPL_DIV` cycles while enabled.
- When disabled, each is forced low within 1 cycle.

## Timing

- All outputs are registered.
- Reset values are 0 for all outputs except `fifo_empty`=1.
- Reset, either source, clears the FIFO, pending flags, shifters, pulse timers and `fifo_ovf`.
- Event latency: an `oLVDS` rising edge increments `fifo_count` 4 cycles later when no other channel is pending. The recorded ts is the counter value at the edge-detect cycle.
- Minimum detectable `oLVDS` pulse width is 2 cycles (10 ns).
- Pop: `fifo_dout` is updated 2 cycles after the strobe's rising edge at `reg_rw` (1 sync register plus the pop).
- Shift: the first `sdata` bit is valid 1 cycle after shift rises. The first `sclk` rise follows `CLK_DIV` cycles later. A full transfer takes 64×`CLK_DIV` cycles.
- Reset mid-transfer aborts immediately, with `sclk`/`sdata` low.

## Test plan

- Master reset for 100 cycles, then trigger=1. Two 2-cycle pulses on `oLVDS[0]` 100 cycles apart → `fifo_count`=2, ch=0, and a ts difference of ≈100.
- Pop twice → `fifo_dout` shows the two events in order; then `fifo_empty`=1 and a third pop leaves `fifo_dout` unchanged.
- Edges on `oLVDS[1]` and `[3]` in the same cycle → ch1 is pushed, then ch3, both with equal ts. With trigger=0, edges → no push.
- `FIFO_DEPTH`+1 events without popping → `fifo_full`=1, `fifo_ovf`=1, count=`FIFO_DEPTH`.
- Word2=0x00008000, load SR, then shift → 32 `sclk` rising edges. `sdata` is high only on bit 16 (the 17th bit) and on none of the other 31 bits. `sclk` then idles. Repeat on interface 2 with word4.
- A loadData edge → a `load_data` pulse of exactly `LOAD_PULSE` cycles. Word0 bits 2/3/16/17/24/25 toggled → the matching pins follow; `opad_clk` has a period of 2×`REPL_DIV`.
